// File: rtl/bram_uart_unpacker_pkg.sv
// Shared types and constants for the BRAM-to-UART readback path.
// The FSM state encoding lives here so that tooling and neighbouring blocks agree on it.
package bram_uart_unpacker_pkg;

    localparam int BYTES_PER_WORD = 2;
    localparam int UART_BYTE_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_SEND_HI = 3'd3,
        ST_SEND_LO = 3'd4,
        ST_DONE    = 3'd5
    } unpack_state_t;

endpackage

// File: rtl/bram_uart_unpacker.sv
// Streams a range of 16-bit BRAM words out as byte pairs (high byte first) over a
// valid/ready link; it is the inverse of the UART-to-BRAM word packer.
module bram_uart_unpacker
    import bram_uart_unpacker_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    output logic [ADDR_WIDTH-1:0] o_addr_bram,
    output logic                  o_rd_en_bram,
    input  logic [DATA_WIDTH-1:0] i_data_bram,
    output logic [UART_BYTE_W-1:0] o_data_uart,
    output logic                  o_valid_uart,
    input  logic                  i_ready_uart,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [1:0]          LAST_WAIT = 2'(RD_LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH + 1)'(1);

    unpack_state_t         state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [1:0]            wait_q, wait_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            bram_addr_q <= '0;
            count_q     <= '0;
            word_q      <= '0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bram_addr_q <= bram_addr_d;
            count_q     <= count_d;
            word_q      <= word_d;
            wait_q      <= wait_d;
        end
    end

    // Outputs decode from the state register only, so ready never reaches valid combinationally.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        count_d      = count_q;
        word_d       = word_q;
        wait_d       = wait_q;
        bram_addr_d  = bram_addr_q;
        o_rd_en_bram = 1'b0;
        o_valid_uart = 1'b0;
        o_data_uart  = '0;
        o_done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    if (i_word_count != '0) begin
                        addr_d  = i_base_addr;
                        count_d = i_word_count;
                        state_d = ST_RD_REQ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RD_REQ: begin
                o_rd_en_bram = 1'b1;
                wait_d       = '0;
                state_d      = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    word_d  = i_data_bram;
                    state_d = ST_SEND_HI;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_SEND_HI: begin
                o_valid_uart = 1'b1;
                o_data_uart  = word_q[DATA_WIDTH-1 -: UART_BYTE_W];
                if (i_ready_uart) begin
                    state_d = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                o_valid_uart = 1'b1;
                o_data_uart  = word_q[UART_BYTE_W-1:0];
                if (i_ready_uart) begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - 1'b1;
                    state_d = (count_q == ONE_WORD) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over everything; a word still in flight from BRAM is simply dropped.
        if (i_abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            word_d  = word_q;
        end

        if (state_d == ST_RD_REQ) begin
            bram_addr_d = addr_d;
        end
    end

    assign o_addr_bram = bram_addr_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bram_uart_unpacker.sv
// Directed bench for bram_uart_unpacker: BRAM models plus a byte/address scoreboard,
// with a second instance at RD_LATENCY=2 used to confirm the start-to-first-byte latency.
module tb_bram_uart_unpacker;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_base_addr;
    logic [8:0]  i_word_count;
    logic        i_ready_uart;

    logic [7:0]  addr1, addr2;
    logic        rd_en1, rd_en2;
    logic [15:0] data1, data2, stage2;
    logic [7:0]  o_data_uart, data_uart2;
    logic        o_valid_uart, valid2;
    logic        o_busy, busy2;
    logic        o_done, done2;

    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    bram_uart_unpacker #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RD_LATENCY(1)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_base_addr(i_base_addr), .i_word_count(i_word_count),
        .o_addr_bram(addr1), .o_rd_en_bram(rd_en1), .i_data_bram(data1),
        .o_data_uart(o_data_uart), .o_valid_uart(o_valid_uart), .i_ready_uart(i_ready_uart),
        .o_busy(o_busy), .o_done(o_done)
    );

    bram_uart_unpacker #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RD_LATENCY(2)) dut_lat2 (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_base_addr(i_base_addr), .i_word_count(i_word_count),
        .o_addr_bram(addr2), .o_rd_en_bram(rd_en2), .i_data_bram(data2),
        .o_data_uart(data_uart2), .o_valid_uart(valid2), .i_ready_uart(1'b1),
        .o_busy(busy2), .o_done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read BRAM models with one and two cycles of latency.
    always @(posedge clk) begin
        if (rd_en1) data1 <= mem[addr1];
        if (rd_en2) stage2 <= mem[addr2];
        data2 <= stage2;
    end

    logic [7:0] exp_q[$];
    logic [7:0] exp_addr[$];

    int   cyc = 0;
    int   start_cyc, first_valid, first_valid2, last_hs_cyc, done_cyc;
    int   hs_count, done_cnt, rd_cnt, valid_cnt;
    bit   rand_ready = 1'b0;
    logic prev_valid = 1'b0, prev_hs = 1'b0, prev_abort = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate one cycle at posedge+1, then advance to the next one.
    task automatic tick();
        logic hs;
        logic [7:0] e;
        if (rand_ready) i_ready_uart = 1'($urandom_range(0, 1));
        hs = o_valid_uart && i_ready_uart;
        if (prev_valid && !prev_hs && !prev_abort) begin
            chk("valid_hold", o_valid_uart, 1);
            chk("data_hold", o_data_uart, prev_data);
        end
        if (hs) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("[TB] FAIL byte_unexpected observed=%0h expected=none", o_data_uart);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("byte", o_data_uart, e);
            end
            hs_count++;
            last_hs_cyc = cyc;
        end
        if (rd_en1) begin
            total++;
            assert (exp_addr.size() > 0) else begin
                bad++;
                $error("[TB] FAIL read_unexpected observed=%0h expected=none", addr1);
            end
            if (exp_addr.size() > 0) begin
                e = exp_addr.pop_front();
                chk("bram_addr", addr1, e);
            end
            rd_cnt++;
        end
        if (o_valid_uart) valid_cnt++;
        if (o_valid_uart && first_valid < 0) first_valid = cyc;
        if (valid2 && first_valid2 < 0) first_valid2 = cyc;
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_valid = o_valid_uart;
        prev_hs    = hs;
        prev_abort = i_abort;
        prev_data  = o_data_uart;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [8:0] cnt);
        logic [7:0]  a;
        logic [15:0] w;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 8'(i);
            w = mem[a];
            exp_addr.push_back(a);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
        hs_count = 0; done_cnt = 0; rd_cnt = 0; valid_cnt = 0;
        first_valid = -1; first_valid2 = -1; last_hs_cyc = -1; done_cyc = -1;
        i_base_addr  = base;
        i_word_count = cnt;
        i_start      = 1'b1;
        start_cyc    = cyc;
        tick();
        i_start = 1'b0;
    endtask

    task automatic checkOutput(input int nwords, input int budget);
        int n = 0;
        while ((o_busy || busy2) && n < budget) begin
            tick();
            n++;
        end
        chk("finish_busy", o_busy, 0);
        chk("finish_busy_lat2", busy2, 0);
        chk("done_count", done_cnt, 1);
        chk("handshakes", hs_count, 2 * nwords);
        chk("reads", rd_cnt, nwords);
        chk("bytes_left", exp_q.size(), 0);
        chk("addrs_left", exp_addr.size(), 0);
        if (nwords > 0) begin
            chk("done_after_last", done_cyc, last_hs_cyc + 1);
            chk("first_byte_lat1", first_valid, start_cyc + 3);
            chk("first_byte_lat2", first_valid2, start_cyc + 4);
        end else begin
            chk("empty_done_cycle", done_cyc, start_cyc + 1);
            chk("empty_no_valid", valid_cnt, 0);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101 + 16'h5a);
        i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0;
        i_base_addr = '0; i_word_count = '0; i_ready_uart = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_addr", addr1, 0);
        chk("rst_rd_en", rd_en1, 0);
        chk("rst_valid", o_valid_uart, 0);
        chk("rst_data", o_data_uart, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        i_rst = 1'b0;
        tick();

        $display("[TB] two words, ready high");
        mem[8'h10] = 16'h1234; mem[8'h11] = 16'hABCD;
        applyStimulus(8'h10, 9'd2);
        checkOutput(2, 100);

        $display("[TB] two words, random ready");
        rand_ready = 1'b1;
        applyStimulus(8'h10, 9'd2);
        checkOutput(2, 300);
        rand_ready = 1'b0;
        i_ready_uart = 1'b1;

        $display("[TB] address wrap");
        mem[8'hFF] = 16'h0102; mem[8'h00] = 16'h0304;
        applyStimulus(8'hFF, 9'd2);
        checkOutput(2, 100);
        chk("addr_hold_after", addr1, 8'h00);

        $display("[TB] zero count");
        applyStimulus(8'h44, 9'd0);
        checkOutput(0, 20);

        $display("[TB] abort in low byte");
        applyStimulus(8'h30, 9'd3);
        n = 0;
        while (hs_count < 1 && n < 50) begin
            tick();
            n++;
        end
        chk("abort_first_hs", hs_count, 1);
        i_ready_uart = 1'b0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        chk("abort_valid_drop", o_valid_uart, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_rd_en", rd_en1, 0);
        repeat (6) tick();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_bytes_left", exp_q.size(), 5);
        chk("abort_addrs_left", exp_addr.size(), 2);
        exp_q.delete();
        exp_addr.delete();
        i_ready_uart = 1'b1;
        mem[8'h20] = 16'hBEEF;
        applyStimulus(8'h20, 9'd1);
        checkOutput(1, 100);

        $display("[TB] start while busy");
        applyStimulus(8'h40, 9'd3);
        repeat (5) tick();
        i_base_addr = 8'h80; i_word_count = 9'd5; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checkOutput(3, 200);

        $display("[TB] full 256-word sweep");
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        applyStimulus(8'h00, 9'd256);
        checkOutput(256, 3000);

        $display("[TB] async reset mid-transfer");
        applyStimulus(8'h10, 9'd2);
        repeat (4) tick();
        i_rst = 1'b1;
        #1;
        chk("midrst_valid", o_valid_uart, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_addr", addr1, 0);
        chk("midrst_done", o_done, 0);
        exp_q.delete();
        exp_addr.delete();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        prev_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bram_uart_unpacker.md
Name: bram_uart_unpacker

Overview:
Reads a contiguous range of 16-bit instruction/data words from CPU BRAM and streams each word to the UART transmitter as two bytes, high byte first. This is the inverse of the UART-to-BRAM loader path, which packs {first byte, second byte} into each word. It is used for memory dump and readback verification over the serial link. It runs in the CPU clock domain and has one BRAM read port and one valid/ready byte stream.

Parameters:
ADDR_WIDTH, 8, BRAM word address width.
DATA_WIDTH, 16, BRAM word width; fixed at 2 bytes, and other values are unsupported.
RD_LATENCY, 1, BRAM read latency in cycles, from o_rd_en_bram to i_data_bram valid; legal values 1..3.

Ports:
i_clk  in  1  CPU clock.
i_rst  in  1  Asynchronous reset, active-high.
i_start  in  1  Single-cycle request; sampled only in IDLE.
i_abort  in  1  Terminates an active transfer.
i_base_addr  in  ADDR_WIDTH  First word address; latched on accepted start.
i_word_count  in  ADDR_WIDTH+1  Number of words to send (0..256); latched on accepted start.
o_addr_bram  out  ADDR_WIDTH  BRAM read address.
o_rd_en_bram  out  1  BRAM read enable, one cycle per word.
i_data_bram  in  DATA_WIDTH  BRAM read data, valid RD_LATENCY cycles after o_rd_en_bram.
o_data_uart  out  8  Byte to the transmitter.
o_valid_uart  out  1  Byte valid.
i_ready_uart  in  1  Transmitter can accept a byte.
o_busy  out  1  High in every state except IDLE.
o_done  out  1  One-cycle pulse when all words have been sent.

Behaviour:
- Reset: all outputs are 0; state is IDLE; internal address, counter and word latch are 0.
- States: IDLE, RD_REQ, RD_WAIT, SEND_HI, SEND_LO, DONE.
- IDLE:
  - i_start=1 with i_word_count!=0: latch base address and count, go to RD_REQ.
  - i_start=1 with i_word_count==0: go to DONE (no BRAM read, no byte sent).
- RD_REQ (one cycle): o_rd_en_bram=1, o_addr_bram=current address. Go to RD_WAIT.
- RD_WAIT: an internal counter waits RD_LATENCY cycles. On the cycle i_data_bram is valid, latch it into the word register and go to SEND_HI.
- SEND_HI:
  - o_valid_uart=1, o_data_uart=word[15:8].
  - On a handshake (valid && ready in the same cycle), go to SEND_LO.
- SEND_LO:
  - o_valid_uart=1, o_data_uart=word[7:0].
  - On a handshake: increment the address, decrement the count.
  - If the remaining count becomes 0, go to DONE; otherwise go to RD_REQ.
- DONE: o_done=1 for exactly one cycle, then IDLE.
- Handshake rules:
  - Once o_valid_uart rises, it holds, and o_data_uart stays stable, until the handshake.
  - No combinational path from i_ready_uart to o_valid_uart.
  - i_ready_uart is ignored when o_valid_uart=0.
- Latency:
  - Accepted start to first valid byte: 2+RD_LATENCY cycles.
  - With i_ready_uart held high, each word takes RD_LATENCY+3 cycles (1 for RD_REQ, RD_LATENCY for RD_WAIT, 1 each for SEND_HI and SEND_LO).
- Address wrap: the address increments modulo 2^ADDR_WIDTH, so 0xFF is followed by 0x00.
  - A count of 256 from base 0 reads every word exactly once.
- i_start while busy: ignored, with no effect on latched values.
- i_abort:
  - In any non-IDLE state, the next state is IDLE. o_valid_uart and o_rd_en_bram drop on the next edge.
  - No o_done pulse. Late-arriving BRAM data is discarded.
  - If i_start and i_abort are both high in IDLE, the abort has priority and the start is ignored.
- Handshake coinciding with abort: the byte counts as sent, and the state still goes to IDLE.
- Reset mid-transfer: reset is asynchronous; everything returns to reset values, with no partial byte or done pulse.
- o_addr_bram holds its last value outside RD_REQ.

Decomposition:
- Shared memory/UART package:
  - State encoding typedef (6 states, 3-bit).
  - Constants BYTES_PER_WORD=2 and UART_BYTE_W=8.
- No sub-module is required. The RD_LATENCY wait counter stays inline.
- The byte serialiser (SEND_HI/SEND_LO together with the word register) could be split out as word_to_byte_serializer. Keep it inline at this size.

Test Plan:
- BRAM[0x10]=0x1234, BRAM[0x11]=0xABCD; start, base=0x10, count=2, ready tied high -> bytes 0x12,0x34,0xAB,0xCD in order; o_done pulses once, 1 cycle after the last handshake; o_busy then low.
- Same setup with ready toggled randomly (50%) -> identical byte sequence; o_data_uart is stable on every cycle where valid=1 and ready=0.
- base=0xFF, count=2, BRAM[0xFF]=0x0102, BRAM[0x00]=0x0304 -> bytes 01,02,03,04; o_addr_bram shows 0xFF, then 0x00.
- count=0 -> no o_rd_en_bram and no o_valid_uart; o_done pulses 1 cycle after start.
- Abort asserted during SEND_LO of word 1 of 3, with ready held low -> valid drops next cycle; no o_done; a later start with base=0x20, count=1 works normally.
- i_start pulsed mid-transfer with different base/count -> ignored, so the original sequence completes unchanged; run with RD_LATENCY=1 and RD_LATENCY=2 -> first valid byte appears at start+3 and start+4 cycles respectively.
